// File: rtl/fifo_reader.sv
// Drains a FIFO with one-cycle read latency into a ready/valid stream through a
// two-entry in-order buffer. The block counts delivered beats and keeps a sticky FIFO-error flag.
module fifo_reader #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 fifo_empty,
   input  logic [WIDTH-1:0]     fifo_rdata,
   input  logic                 fifo_error,
   output logic                 fifo_rd_en,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   input  logic                 out_ready,
   output logic [CNT_WIDTH-1:0] drain_cnt,
   output logic                 err,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           occ_q, occ_d;
   logic                 pend_q, pend_d;
   logic [WIDTH-1:0]     buf0_q, buf0_d;
   logic [WIDTH-1:0]     buf1_q, buf1_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 pop_s;
   logic [1:0]           level_s;
   logic [1:0]           wr_idx_s;

   // Stream outputs and read issue; occ + pend never exceeds 2, so 2-bit arithmetic is exact.
   always_comb begin
      out_valid  = (occ_q != 2'd0);
      out_data   = out_valid ? buf0_q : {WIDTH{1'b0}};
      pop_s      = out_valid && out_ready;
      level_s    = occ_q + {1'b0, pend_q} - {1'b0, pop_s};
      fifo_rd_en = rst && (state_q == RUN) && !fifo_empty && (level_s < 2'd2);
      busy       = (state_q != IDLE) || (occ_q != 2'd0) || pend_q;
      drain_cnt  = cnt_q;
      err        = err_q;
   end

   // Control state transitions.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (enable) state_d = RUN;
            else        state_d = IDLE;
         end
         RUN: begin
            if (!enable) state_d = STOP;
            else         state_d = RUN;
         end
         STOP: begin
            if (enable)                           state_d = RUN;
            else if (!pend_q && occ_q == 2'd0)    state_d = IDLE;
            else                                  state_d = STOP;
         end
         default: state_d = IDLE;
      endcase
   end

   // Buffer shift on pop, then the returning read lands behind whatever survives.
   always_comb begin
      buf0_d   = buf0_q;
      buf1_d   = buf1_q;
      wr_idx_s = occ_q - {1'b0, pop_s};
      if (pop_s) buf0_d = buf1_q;
      else       buf0_d = buf0_q;
      if (pend_q) begin
         case (wr_idx_s)
            2'd0:    buf0_d = fifo_rdata;
            2'd1:    buf1_d = fifo_rdata;
            default: buf1_d = buf1_q;
         endcase
      end else begin
         buf1_d = buf1_d;
      end
      occ_d  = occ_q + {1'b0, pend_q} - {1'b0, pop_s};
      pend_d = fifo_rd_en;
      cnt_d  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop_s};
      err_d  = err_q | fifo_error;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         occ_q   <= 2'd0;
         pend_q  <= 1'b0;
         buf0_q  <= {WIDTH{1'b0}};
         buf1_q  <= {WIDTH{1'b0}};
         cnt_q   <= {CNT_WIDTH{1'b0}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         pend_q  <= pend_d;
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a one-cycle-latency FIFO model feeds the DUT and
// each scenario task compares captured beats and flags against hand-computed values.
module tb_fifo_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        fifo_empty;
   logic [7:0]  fifo_rdata;
   logic        fifo_error;
   logic        fifo_rd_en;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic [15:0] drain_cnt;
   logic        err;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_cnt, vcnt, stab_err, empty_rd_err;
   logic        prev_stall;
   logic [7:0]  prev_data;
   logic [7:0]  fq[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int          beat_cyc[$];

   always #5 clk = ~clk;

   fifo_reader #(.WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_rdata(fifo_rdata), .fifo_error(fifo_error), .fifo_rd_en(fifo_rd_en),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .drain_cnt(drain_cnt), .err(err), .busy(busy)
   );

   // One clock cycle: sample DUT mid-cycle, then advance the FIFO model after the edge.
   task automatic tick();
      logic rd_s, v_s, r_s;
      logic [7:0] d_s;
      #2;
      rd_s = fifo_rd_en; v_s = out_valid; r_s = out_ready; d_s = out_data;
      if (rd_s) rd_cnt++;
      if (rd_s && fifo_empty) empty_rd_err++;
      if (v_s) vcnt++;
      if (v_s && r_s) begin
         got_q.push_back(d_s);
         beat_cyc.push_back(cyc);
      end
      if (prev_stall && v_s && d_s !== prev_data) stab_err++;
      prev_stall = v_s && !r_s;
      prev_data  = d_s;
      @(posedge clk);
      #1;
      cyc++;
      if (rd_s && fq.size() > 0) fifo_rdata = fq.pop_front();
      else                       fifo_rdata = 8'hA5;
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic push(input logic [7:0] d);
      fq.push_back(d);
      exp_q.push_back(d);
      fifo_empty = 1'b0;
   endtask

   task automatic clear_counts();
      rd_cnt = 0; vcnt = 0; stab_err = 0; empty_rd_err = 0;
      prev_stall = 1'b0; prev_data = 8'h00;
      exp_q.delete(); got_q.delete(); beat_cyc.delete();
   endtask

   task automatic do_reset();
      rst = 1'b0; enable = 1'b0; out_ready = 1'b0; fifo_error = 1'b0;
      fq.delete(); fifo_empty = 1'b1;
      tick(); tick();
      clear_counts();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; enable = 1'b1; out_ready = 1'b1; fifo_error = 1'b0;
      fq.delete();
      for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
      tick(); tick();
      checks += 6;
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
      if (drain_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", drain_cnt); end
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++;
      if (fq.size() != 4) begin errors++; $display("FAIL reset_no_pop: got %0d entries expected 4", fq.size()); end
   endtask

   task automatic test_stream();
      int start;
      do_reset();
      for (int i = 0; i < 32; i++) push(8'((i * 37 + 11) & 255));
      out_ready = 1'b1; enable = 1'b1; start = cyc;
      for (int i = 0; i < 60 && got_q.size() < 32; i++) tick();
      tick(); tick();
      checks++;
      if (rd_cnt != 32) begin errors++; $display("FAIL stream_reads: got %0d expected 32", rd_cnt); end
      checks++;
      if (got_q.size() != 32) begin errors++; $display("FAIL stream_beats: got %0d expected 32", got_q.size()); end
      for (int i = 0; i < 32 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      if (beat_cyc.size() == 32) begin
         checks += 2;
         if (beat_cyc[0] - start != 3) begin errors++; $display("FAIL stream_latency: got %0d expected 3", beat_cyc[0] - start); end
         if (beat_cyc[31] - beat_cyc[0] != 31) begin errors++; $display("FAIL stream_b2b: got %0d expected 31", beat_cyc[31] - beat_cyc[0]); end
      end
      checks++;
      if (drain_cnt !== 16'd32) begin errors++; $display("FAIL stream_cnt: got %0d expected 32", drain_cnt); end
      enable = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy: got %b expected 0", busy); end
      if (empty_rd_err != 0) begin errors++; $display("FAIL stream_empty_rd: got %0d expected 0", empty_rd_err); end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 15; i++) push(8'(8'hC0 + i * 3));
      out_ready = 1'b0; enable = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      checks += 3;
      if (rd_cnt != 2) begin errors++; $display("FAIL bp_stall_reads: got %0d expected 2", rd_cnt); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid: got %b expected 1", out_valid); end
      if (out_data !== 8'hC0) begin errors++; $display("FAIL bp_stall_data: got %h expected c0", out_data); end
      for (int i = 0; i < 300 && got_q.size() < 15; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      out_ready = 1'b1;
      tick(); tick(); tick();
      checks += 4;
      if (got_q.size() != 15) begin errors++; $display("FAIL bp_beats: got %0d expected 15", got_q.size()); end
      if (rd_cnt != 15) begin errors++; $display("FAIL bp_reads: got %0d expected 15", rd_cnt); end
      if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", stab_err); end
      if (drain_cnt !== 16'd15) begin errors++; $display("FAIL bp_cnt: got %0d expected 15", drain_cnt); end
      for (int i = 0; i < 15 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_empty();
      do_reset();
      out_ready = 1'b1; enable = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      checks += 3;
      if (rd_cnt != 0) begin errors++; $display("FAIL empty_reads: got %0d expected 0", rd_cnt); end
      if (vcnt != 0) begin errors++; $display("FAIL empty_valid: got %0d expected 0", vcnt); end
      if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy: got %b expected 1", busy); end
      push(8'h5C);
      for (int i = 0; i < 10; i++) tick();
      checks += 3;
      if (rd_cnt != 1) begin errors++; $display("FAIL empty_one_read: got %0d expected 1", rd_cnt); end
      if (got_q.size() != 1) begin errors++; $display("FAIL empty_one_beat: got %0d expected 1", got_q.size()); end
      else if (got_q[0] !== 8'h5C) begin errors++; $display("FAIL empty_one_data: got %h expected 5c", got_q[0]); end
      if (empty_rd_err != 0) begin errors++; $display("FAIL empty_rd_while_empty: got %0d expected 0", empty_rd_err); end
   endtask

   task automatic test_stop();
      do_reset();
      for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
      out_ready = 1'b1; enable = 1'b1;
      tick(); tick(); tick();
      #1;
      checks++;
      if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL stop_rd_issued: got %b expected 1", fifo_rd_en); end
      enable = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checks += 5;
      if (rd_cnt != 3) begin errors++; $display("FAIL stop_reads: got %0d expected 3", rd_cnt); end
      if (got_q.size() != 3) begin errors++; $display("FAIL stop_beats: got %0d expected 3", got_q.size()); end
      else if (got_q[2] !== 8'h42) begin errors++; $display("FAIL stop_last: got %h expected 42", got_q[2]); end
      if (fq.size() != 7) begin errors++; $display("FAIL stop_left: got %0d expected 7", fq.size()); end
      if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b expected 0", busy); end
      if (drain_cnt !== 16'd3) begin errors++; $display("FAIL stop_cnt: got %0d expected 3", drain_cnt); end
   endtask

   task automatic test_error();
      int bad = 0;
      do_reset();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_init: got %b expected 0", err); end
      fifo_error = 1'b1;
      tick();
      fifo_error = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (err !== 1'b1) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL err_hold: got %0d low cycles expected 0", bad); end
      rst = 1'b0;
      tick();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; out_ready = 1'b0; fifo_error = 1'b0;
      fifo_empty = 1'b1; fifo_rdata = 8'hA5;
      clear_counts();
      test_reset();
      test_stream();
      test_backpressure();
      test_empty();
      test_stop();
      test_error();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter WIDTH, default 8, data width of FIFO read port and output stream.
REQ-002 Parameter CNT_WIDTH, default 16, width of the drained-beat counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled on posedge clk.
REQ-005 enable  input  1  1 = drain FIFO; 0 = stop issuing reads.
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_rdata  input  WIDTH  FIFO read data, valid the cycle after the cycle fifo_rd_en was high.
REQ-008 fifo_error  input  1  FIFO error flag (overflow/underflow).
REQ-009 fifo_rd_en  output  1  FIFO pop request.
REQ-010 out_valid  output  1  output beat valid.
REQ-011 out_data  output  WIDTH  output beat data.
REQ-012 out_ready  input  1  downstream accepts beat.
REQ-013 drain_cnt  output  CNT_WIDTH  count of accepted output beats.
REQ-014 err  output  1  sticky FIFO-error flag.
REQ-015 busy  output  1  block not idle or holding/awaiting data.

Function
REQ-016 Read latency is fixed: fifo_rd_en high in cycle N -> fifo_rdata captured at end of cycle N+1 -> beat visible on out_valid/out_data from cycle N+2.
REQ-017 Internal 2-entry in-order output buffer; occ = entries held (0..2); pend = 1 if read issued the previous cycle.
REQ-018 pop = out_valid && out_ready; out_valid = (occ != 0); out_data = oldest entry, 0 when occ = 0.
REQ-019 fifo_rd_en = (state == RUN) && !fifo_empty && (occ + pend - pop < 2); combinational path from out_ready is permitted.
REQ-020 Capture (pend = 1) and pop in the same cycle are both applied; occ updated by +capture -pop; no entry lost, duplicated or reordered.
REQ-021 fifo_rd_en is never asserted while fifo_empty = 1 or in any state other than RUN.
REQ-022 With out_ready held 1 and FIFO non-empty, one beat per cycle is sustained.
REQ-023 out_data is stable while out_valid = 1 and out_ready = 0.
REQ-024 States: IDLE, RUN, STOP.
REQ-025 IDLE -> RUN when enable = 1; otherwise stay IDLE.
REQ-026 RUN -> STOP when enable = 0.
REQ-027 STOP -> RUN when enable = 1. STOP -> IDLE when enable = 0, pend = 0 and occ = 0.
REQ-028 In STOP, the in-flight read is still captured and buffered beats are still delivered.
REQ-029 drain_cnt increments by 1 on each pop; wraps modulo 2^CNT_WIDTH.
REQ-030 err sets when fifo_error = 1 on a clock edge and holds until reset; err does not block operation.
REQ-031 busy = (state != IDLE) || (occ != 0) || (pend != 0).

Reset
REQ-032 While rst = 0 at a clock edge, the following are forced: state = IDLE, occ = 0, pend = 0, drain_cnt = 0, err = 0.
REQ-033 During and after reset, fifo_rd_en = 0, out_valid = 0, out_data = 0 and busy = 0 until state leaves IDLE.
REQ-034 Reset mid-operation discards buffered and in-flight data; the FIFO read data returned the cycle after reset is ignored.

Verification
REQ-035 Reset: rst = 0 for 2 cycles with enable = 1 and FIFO non-empty -> fifo_rd_en, out_valid, out_data, drain_cnt, err and busy all 0.
REQ-036 Stream: FIFO model preloaded with 32 random bytes, enable = 1, out_ready = 1 -> fifo_rd_en high exactly 32 cycles; 32 beats in write order, back-to-back after first-beat latency; drain_cnt = 32; busy = 0 in STOP/IDLE afterwards.
REQ-037 Backpressure: 15 entries, out_ready = 0 for 10 cycles then random -> at most 2 reads issued while stalled; out_data stable while stalled; all 15 beats delivered once, in order.
REQ-038 Empty: fifo_empty = 1, enable = 1 for 20 cycles -> fifo_rd_en = 0, out_valid = 0, busy = 1 (RUN); push 1 entry -> exactly one beat delivered.
REQ-039 Stop mid-stream: enable falls in the cycle a read is issued -> that entry plus the buffered entries are delivered; no further reads; return to IDLE, busy = 0.
REQ-040 Error: single-cycle fifo_error pulse -> err = 1 from the next cycle, held for 50 cycles until rst = 0 clears it.
